// File: rtl/riscv_ctrl_pkg.sv
// Shared definitions for the RV32I multi-cycle controller: opcode[6:2] values,
// FSM state encoding, and the pc_sel / wb_sel / trap_cause encodings.
package riscv_ctrl_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;
    localparam logic [1:0] WB_IMM  = 2'd3;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_IMEM    = 2'd2;
    localparam logic [1:0] CAUSE_DMEM    = 2'd3;

    function automatic logic is_legal(input logic [4:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH: is_legal = 1'b1;
            default:                                  is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Memory-wait watchdog. Counts cycles with en high; expired flags the cycle in
// which the MEM_TIMEOUT-th consecutive waiting cycle is being spent, so the FSM
// can leave on that same edge.
//  clk, rst : clock, synchronous active-high reset
//  en       : a request is outstanding and ready is low this cycle
//  clr      : restart count (state exit or reset); wins over en
//  expired  : this is the last permitted waiting cycle
module ctrl_watchdog #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)     cnt_d = '0;
        else if (en) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // cnt_q holds the number of earlier waiting cycles, so this cycle is number cnt_q+1.
    assign expired = en && (cnt_q == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core. Sequences FETCH, DECODE, EXEC,
// MEM, WB over shared datapath resources, with a watchdog on memory waits and
// a terminal TRAP state.
//  clk, rst               : clock, synchronous active-high reset
//  opcode/func3/func7     : decoded IR fields, valid from DECODE onward
//  branch_taken           : comparator result, used in EXEC for BRANCH
//  imem_ready/dmem_ready  : memory handshakes
//  imem_req, ir_we        : fetch request and IR latch strobe
//  dmem_req, dmem_we      : data access request and store qualifier
//  pc_we, pc_sel          : PC update and source
//  reg_we, wb_sel         : regfile write and source
//  alu_src_a/b, alu_op    : ALU operand muxes and operation
//  halt, trap_cause       : trap status
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       branch_taken,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       imem_req,
    output logic       ir_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       pc_we,
    output logic [1:0] pc_sel,
    output logic       reg_we,
    output logic [1:0] wb_sel,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [3:0] alu_op,
    output logic       halt,
    output logic [1:0] trap_cause
);

    state_t     state_q, state_d;
    logic [1:0] cause_q, cause_d;
    logic       wd_en, wd_clr, wd_expired;

    ctrl_watchdog #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .CNT_W      (CNT_W)
    ) u_wd (
        .clk    (clk),
        .rst    (rst),
        .en     (wd_en),
        .clr    (wd_clr),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end
    end

    assign wd_clr     = rst || (state_d != state_q);
    assign trap_cause = cause_q;

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        wd_en     = 1'b0;
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        alu_src_a = 1'b0;
        alu_src_b = 1'b0;
        alu_op    = 4'b0000;
        halt      = 1'b0;

        // Everything stays quiet while rst is high, so a reset landing mid-instruction
        // never leaks a write or request in its own cycle.
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    wd_en    = !imem_ready;
                    if (imem_ready) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (wd_expired) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_IMEM;
                    end
                end
                S_DECODE: begin
                    if (is_legal(opcode)) begin
                        state_d = S_EXEC;
                    end else begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OPC_OP:     alu_op = {func7, func3};
                        // Only the shift-right-immediate encoding carries func7 (SRAI vs SRLI).
                        OPC_OP_IMM: alu_op = {(func3 == 3'b101) ? func7 : 1'b0, func3};
                        default:    alu_op = 4'b0000;
                    endcase
                    case (opcode)
                        OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_JALR: alu_src_b = 1'b1;
                        OPC_AUIPC, OPC_JAL: begin
                            alu_src_a = 1'b1;
                            alu_src_b = 1'b1;
                        end
                        default: ;
                    endcase
                    case (opcode)
                        OPC_BRANCH: begin
                            pc_we   = 1'b1;
                            pc_sel  = branch_taken ? PC_IMM : PC_PLUS4;
                            state_d = S_FETCH;
                        end
                        OPC_LOAD, OPC_STORE: state_d = S_MEM;
                        default:             state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (opcode == OPC_STORE);
                    wd_en    = !dmem_ready;
                    if (dmem_ready) begin
                        if (opcode == OPC_STORE) begin
                            pc_we   = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (wd_expired) begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_DMEM;
                    end
                end
                S_WB: begin
                    reg_we = 1'b1;
                    pc_we  = 1'b1;
                    case (opcode)
                        OPC_LOAD: wb_sel = WB_LOAD;
                        OPC_JAL: begin
                            wb_sel = WB_PC4;
                            pc_sel = PC_IMM;
                        end
                        OPC_JALR: begin
                            wb_sel = WB_PC4;
                            pc_sel = PC_JALR;
                        end
                        OPC_LUI:  wb_sel = WB_IMM;
                        default:  wb_sel = WB_ALU;
                    endcase
                    state_d = S_FETCH;
                end
                S_TRAP: begin
                    halt = 1'b1;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int TO = 16;

    localparam logic [4:0] LOAD = 5'b00000, STORE = 5'b01000, OPIMM = 5'b00100, OP = 5'b01100;
    localparam logic [4:0] LUI = 5'b01101, AUIPC = 5'b00101, JAL = 5'b11011, JALR = 5'b11001;
    localparam logic [4:0] BR = 5'b11000;
    localparam logic [4:0] LEGAL [9] = '{LOAD, STORE, OPIMM, OP, LUI, AUIPC, JAL, JALR, BR};

    typedef enum {P_F, P_D, P_E, P_M, P_W, P_T} phase_e;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] opcode = '0;
    logic [2:0] func3 = '0;
    logic       func7 = 1'b0, branch_taken = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
    logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, alu_src_a, alu_src_b, halt;
    logic [1:0] pc_sel, wb_sel, trap_cause;
    logic [3:0] alu_op;

    int total = 0;
    int bad = 0;
    logic [16:0] obs_a [64];

    multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func3(func3), .func7(func7),
        .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we), .wb_sel(wb_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .halt(halt), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    // Observed bundle: {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we, wb_sel, alu_op, halt, cause}
    function automatic logic [16:0] obs_now();
        return {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, reg_we, wb_sel, alu_op, halt, trap_cause};
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return (op == LOAD) || (op == STORE);
    endfunction

    function automatic int ilen(input logic [4:0] op, input int iw, input int dw);
        return iw + 3 + (is_mem(op) ? dw + 1 : 0) + ((op != BR && op != STORE) ? 1 : 0);
    endfunction

    function automatic phase_e phase_at(input logic [4:0] op, input int iw, input int dw, input int c);
        if (c <= iw) return P_F;
        if (c == iw + 1) return P_D;
        if (c == iw + 2) return P_E;
        if (is_mem(op) && c <= iw + 3 + dw) return P_M;
        return P_W;
    endfunction

    function automatic logic rdy_at(input logic [4:0] op, input int iw, input int dw, input int c);
        phase_e ph;
        ph = phase_at(op, iw, dw, c);
        return (ph == P_F && c == iw) || (ph == P_M && c == iw + 3 + dw);
    endfunction

    // Expected outputs for one cycle, from the phase the instruction is in.
    function automatic logic [16:0] exp_vec(input phase_e ph, input logic [4:0] op, input logic [2:0] f3,
                                            input logic f7, input logic tk, input logic rdy, input logic [1:0] cs);
        logic ireq, irwe, dreq, dwe, pcwe, rwe, hlt;
        logic [1:0] psel, wsel, cause;
        logic [3:0] aop;
        ireq = 0; irwe = 0; dreq = 0; dwe = 0; pcwe = 0; rwe = 0; hlt = 0;
        psel = 0; wsel = 0; cause = 0; aop = 0;
        case (ph)
            P_F: begin ireq = 1; irwe = rdy; end
            P_E: begin
                if (op == OP) aop = {f7, f3};
                else if (op == OPIMM) aop = {(f3 == 3'd5) ? f7 : 1'b0, f3};
                if (op == BR) begin pcwe = 1; psel = tk ? 2'd1 : 2'd0; end
            end
            P_M: begin
                dreq = 1; dwe = (op == STORE);
                if (rdy && op == STORE) pcwe = 1;
            end
            P_W: begin
                rwe = 1; pcwe = 1;
                wsel = (op == LOAD) ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : (op == LUI) ? 2'd3 : 2'd0;
                psel = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
            end
            P_T: begin hlt = 1; cause = cs; end
            default: ;
        endcase
        return {ireq, irwe, dreq, dwe, pcwe, psel, rwe, wsel, aop, hlt, cause};
    endfunction

    // Leaves the DUT freshly reset, in FETCH, with the next negedge starting its first cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1; imem_ready = 0; dmem_ready = 0;
        @(posedge clk);
        #1 rst = 0;
    endtask

    // Drives one instruction with the given ready delays and records outputs per cycle.
    task automatic run_instr(input logic [4:0] op, input logic [2:0] f3, input logic f7, input logic tk,
                             input int iw, input int dw, output int n);
        n = ilen(op, iw, dw);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == 0) begin opcode = op; func3 = f3; func7 = f7; branch_taken = tk; end
            imem_ready = (phase_at(op, iw, dw, c) == P_F) && rdy_at(op, iw, dw, c);
            dmem_ready = (phase_at(op, iw, dw, c) == P_M) && rdy_at(op, iw, dw, c);
            #1 obs_a[c] = obs_now();
        end
    endtask

    task automatic test_reset();
        logic [16:0] e;
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (obs_now() !== 17'd0) begin bad++; $display("FAIL reset_hold got=%b want=%b", obs_now(), 17'd0); end
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        #1;
        e = exp_vec(P_F, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs_now() !== e) begin bad++; $display("FAIL reset_fetch got=%b want=%b", obs_now(), e); end
    endtask

    task automatic test_op_alu();
        logic [4:0] ops [4] = '{OP, OP, OPIMM, OPIMM};
        logic [2:0] f3s [4] = '{3'b000, 3'b000, 3'b101, 3'b000};
        logic       f7s [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] want [4] = '{4'b0000, 4'b1000, 4'b1101, 4'b0000};
        logic [16:0] e;
        int n;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_instr(ops[k], f3s[k], f7s[k], 1'b0, 0, 0, n);
            for (int c = 0; c < n; c++) begin
                e = exp_vec(phase_at(ops[k], 0, 0, c), ops[k], f3s[k], f7s[k], 1'b0, rdy_at(ops[k], 0, 0, c), 2'd0);
                total++;
                if (obs_a[c] !== e) begin bad++; $display("FAIL op_alu%0d cyc%0d got=%b want=%b", k, c, obs_a[c], e); end
            end
            total++;
            if (obs_a[2][6:3] !== want[k]) begin bad++; $display("FAIL alu_op%0d got=%b want=%b", k, obs_a[2][6:3], want[k]); end
            total++;
            if (obs_a[3][9] !== 1'b1) begin bad++; $display("FAIL reg_we_4th%0d got=%b want=1", k, obs_a[3][9]); end
        end
    endtask

    task automatic test_load_wait();
        logic [16:0] e;
        int n, reqs;
        do_reset();
        run_instr(LOAD, 3'b010, 1'b0, 1'b0, 0, 3, n);
        reqs = 0;
        for (int c = 0; c < n; c++) begin
            e = exp_vec(phase_at(LOAD, 0, 3, c), LOAD, 3'b010, 1'b0, 1'b0, rdy_at(LOAD, 0, 3, c), 2'd0);
            total++;
            if (obs_a[c] !== e) begin bad++; $display("FAIL load_wait cyc%0d got=%b want=%b", c, obs_a[c], e); end
            reqs += int'(obs_a[c][14]);
        end
        total++;
        if (reqs !== 4) begin bad++; $display("FAIL load_req_cycles got=%0d want=4", reqs); end
        total++;
        if (obs_a[7][9:7] !== 3'b101) begin bad++; $display("FAIL load_wb_8th got=%b want=101", obs_a[7][9:7]); end
    endtask

    task automatic test_branch();
        logic [16:0] e;
        int n;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            run_instr(BR, 3'b001, 1'b0, (k == 0), 0, 0, n);
            for (int c = 0; c < n; c++) begin
                e = exp_vec(phase_at(BR, 0, 0, c), BR, 3'b001, 1'b0, (k == 0), rdy_at(BR, 0, 0, c), 2'd0);
                total++;
                if (obs_a[c] !== e) begin bad++; $display("FAIL branch%0d cyc%0d got=%b want=%b", k, c, obs_a[c], e); end
            end
        end
    endtask

    task automatic test_random();
        logic [16:0] e;
        logic [4:0] op;
        logic [2:0] f3;
        logic f7, tk;
        int iw, dw, n;
        do_reset();
        for (int k = 0; k < 40; k++) begin
            op = LEGAL[$urandom_range(0, 8)];
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            tk = 1'($urandom_range(0, 1));
            iw = $urandom_range(0, 12);
            dw = $urandom_range(0, 12);
            run_instr(op, f3, f7, tk, iw, dw, n);
            for (int c = 0; c < n; c++) begin
                e = exp_vec(phase_at(op, iw, dw, c), op, f3, f7, tk, rdy_at(op, iw, dw, c), 2'd0);
                total++;
                if (obs_a[c] !== e) begin
                    bad++;
                    $display("FAIL rand%0d op=%b cyc%0d got=%b want=%b", k, op, c, obs_a[c], e);
                end
            end
        end
    endtask

    task automatic test_illegal();
        logic [16:0] e;
        logic [4:0] ill [2];
        logic [4:0] cand;
        ill[0] = 5'b11111;
        ill[1] = 5'b11111;
        for (int t = 0; t < 100; t++) begin
            cand = 5'($urandom_range(0, 31));
            if (!(cand inside {LOAD, STORE, OPIMM, OP, LUI, AUIPC, JAL, JALR, BR})) begin ill[1] = cand; break; end
        end
        for (int k = 0; k < 2; k++) begin
            do_reset();
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                if (c == 0) opcode = ill[k];
                imem_ready = (c == 0) || (c >= 2);
                dmem_ready = (c >= 2);
                #1;
                e = (c == 0) ? exp_vec(P_F, 0, 0, 0, 0, 1, 0) :
                    (c == 1) ? exp_vec(P_D, 0, 0, 0, 0, 0, 0) : exp_vec(P_T, 0, 0, 0, 0, 0, 2'd1);
                total++;
                if (obs_now() !== e) begin bad++; $display("FAIL illegal%0d cyc%0d got=%b want=%b", k, c, obs_now(), e); end
            end
            @(negedge clk);
            rst = 1; imem_ready = 0; dmem_ready = 0;
            @(posedge clk);
            #1 rst = 0;
            @(negedge clk);
            #1;
            e = exp_vec(P_F, 0, 0, 0, 0, 0, 0);
            total++;
            if (obs_now() !== e) begin bad++; $display("FAIL trap_reset%0d got=%b want=%b", k, obs_now(), e); end
        end
    endtask

    task automatic test_imem_timeout();
        logic [16:0] e;
        int n;
        do_reset();
        for (int c = 0; c < TO + 3; c++) begin
            @(negedge clk);
            imem_ready = (c > TO);
            #1;
            e = (c < TO) ? exp_vec(P_F, 0, 0, 0, 0, 0, 0) : exp_vec(P_T, 0, 0, 0, 0, 0, 2'd2);
            total++;
            if (obs_now() !== e) begin bad++; $display("FAIL imem_to cyc%0d got=%b want=%b", c, obs_now(), e); end
        end
        // Ready on the last permitted cycle completes normally.
        do_reset();
        run_instr(OP, 3'b111, 1'b0, 1'b0, TO - 1, 0, n);
        for (int c = 0; c < n; c++) begin
            e = exp_vec(phase_at(OP, TO - 1, 0, c), OP, 3'b111, 1'b0, 1'b0, rdy_at(OP, TO - 1, 0, c), 2'd0);
            total++;
            if (obs_a[c] !== e) begin bad++; $display("FAIL imem_edge cyc%0d got=%b want=%b", c, obs_a[c], e); end
        end
    endtask

    task automatic test_dmem_timeout();
        logic [16:0] e;
        do_reset();
        for (int c = 0; c < TO + 5; c++) begin
            @(negedge clk);
            if (c == 0) opcode = STORE;
            imem_ready = (c == 0);
            dmem_ready = 0;
            #1;
            e = (c == 0) ? exp_vec(P_F, STORE, 0, 0, 0, 1, 0) :
                (c == 1) ? exp_vec(P_D, STORE, 0, 0, 0, 0, 0) :
                (c == 2) ? exp_vec(P_E, STORE, 0, 0, 0, 0, 0) :
                (c < TO + 3) ? exp_vec(P_M, STORE, 0, 0, 0, 0, 0) : exp_vec(P_T, STORE, 0, 0, 0, 0, 2'd3);
            total++;
            if (obs_now() !== e) begin bad++; $display("FAIL dmem_to cyc%0d got=%b want=%b", c, obs_now(), e); end
        end
    endtask

    task automatic test_mid_reset();
        logic [16:0] e;
        do_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 0) opcode = LOAD;
            imem_ready = (c == 0);
        end
        @(negedge clk);
        rst = 1; imem_ready = 0; dmem_ready = 0;
        #1;
        total++;
        if (obs_now() !== 17'd0) begin bad++; $display("FAIL mid_rst_quiet got=%b want=%b", obs_now(), 17'd0); end
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        #1;
        e = exp_vec(P_F, 0, 0, 0, 0, 0, 0);
        total++;
        if (obs_now() !== e) begin bad++; $display("FAIL mid_rst_fetch got=%b want=%b", obs_now(), e); end
    endtask

    initial begin
        test_reset();
        test_op_alu();
        test_load_wait();
        test_branch();
        test_random();
        test_illegal();
        test_imem_timeout();
        test_dmem_timeout();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
